// File: rtl/phase_counter_if.sv
// Phase counter bus definitions.
// CONFIG holds the default period width shared by the interface and the counter.
// phase_counter_if groups the tick/period request inputs and the
// elapsed/period outputs that feed the downstream divider.
package CONFIG;
    localparam int PERIOD_WIDTH = 8;
endpackage

interface phase_counter_if #(
    parameter int PERIOD_WIDTH = CONFIG::PERIOD_WIDTH
);
    logic                    sample_tick;
    logic [PERIOD_WIDTH-1:0] period_in;
    logic                    period_valid;
    logic                    note_on;
    logic [PERIOD_WIDTH-1:0] elapsed;
    logic [PERIOD_WIDTH-1:0] period_out;
    logic                    out_valid;
    logic                    wrap;

    // Stimulus side: drives requests, observes the phase outputs.
    modport master (
        output sample_tick, period_in, period_valid, note_on,
        input  elapsed, period_out, out_valid, wrap
    );

    // Counter side: consumes requests, produces the phase outputs.
    modport slave (
        input  sample_tick, period_in, period_valid, note_on,
        output elapsed, period_out, out_valid, wrap
    );
endinterface

// File: rtl/phase_counter.sv
// Oscillator phase counter.
// Counts sample ticks within the active period and pulses wrap at each period
// boundary. A new period requested mid-run is queued and takes effect at the
// next wrap; a zero period stops the counter.
// Optional feature: define PHASE_RESET_EN to let note_on restart the phase
// (and apply any queued period) without a wrap pulse.
module phase_counter #(
    parameter int PERIOD_WIDTH = CONFIG::PERIOD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    phase_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [PERIOD_WIDTH-1:0] elapsed_q,   elapsed_d;
    logic [PERIOD_WIDTH-1:0] period_q,    period_d;
    logic [PERIOD_WIDTH-1:0] pending_q,   pending_d;
    logic                    out_valid_q, out_valid_d;
    logic                    wrap_q,      wrap_d;

    logic load_req;
    logic stop_req;
    logic at_end;

    assign load_req = bus.period_valid && (bus.period_in != '0);
    assign stop_req = bus.period_valid && (bus.period_in == '0);
    // period_q is nonzero whenever this matters (RUN/PEND), so the subtract cannot underflow there.
    assign at_end   = bus.sample_tick && (elapsed_q == (period_q - PERIOD_WIDTH'(1)));

    // Next-state and next-output computation for the counter.
    always_comb begin
        state_d     = state_q;
        elapsed_d   = elapsed_q;
        period_d    = period_q;
        pending_d   = pending_q;
        wrap_d      = 1'b0;

        if (stop_req) begin
            // A zero period stops everything regardless of state.
            state_d   = IDLE;
            elapsed_d = '0;
            period_d  = '0;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ticks are ignored until a period is supplied.
                    if (load_req) begin
                        state_d   = RUN;
                        elapsed_d = '0;
                        period_d  = bus.period_in;
                        pending_d = '0;
                    end
                end
                RUN, PEND: begin
`ifdef PHASE_RESET_EN
                    if (bus.note_on) begin
                        // Phase restart: the freshest period request takes effect now, no wrap pulse.
                        state_d   = RUN;
                        elapsed_d = '0;
                        pending_d = '0;
                        if (load_req) begin
                            period_d = bus.period_in;
                        end else if (state_q == PEND) begin
                            period_d = pending_q;
                        end
                    end else
`endif
                    if (at_end) begin
                        // Boundary crossing: a coincident request beats the queued one.
                        state_d   = RUN;
                        elapsed_d = '0;
                        wrap_d    = 1'b1;
                        pending_d = '0;
                        if (load_req) begin
                            period_d = bus.period_in;
                        end else if (state_q == PEND) begin
                            period_d = pending_q;
                        end
                    end else begin
                        if (bus.sample_tick) begin
                            elapsed_d = elapsed_q + PERIOD_WIDTH'(1);
                        end
                        if (load_req) begin
                            // Last request wins while waiting for the wrap.
                            state_d   = PEND;
                            pending_d = bus.period_in;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    elapsed_d = '0;
                    period_d  = '0;
                    pending_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d != IDLE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elapsed_q   <= '0;
            period_q    <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            elapsed_q   <= elapsed_d;
            period_q    <= period_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.elapsed    = elapsed_q;
    assign bus.period_out = period_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_phase_counter.sv
// Testbench for phase_counter: directed vector table, hand-written reset and
// note_on sequences, then randomized traffic against a behavioural model.
module tb_phase_counter;

    localparam int W = CONFIG::PERIOD_WIDTH;
`ifdef PHASE_RESET_EN
    localparam bit NOTE_EN = 1'b1;
`else
    localparam bit NOTE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    phase_counter_if #(.PERIOD_WIDTH(W)) bus_if ();

    phase_counter #(.PERIOD_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         tick;
        bit         pv;
        logic [W-1:0] pin;
        bit         note;
        logic [W-1:0] el;
        logic [W-1:0] per;
        bit         valid;
        bit         wrap;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: m_per == 0 means stopped.
    int m_per, m_el, m_pend;
    bit m_has_pend, m_wrap;

    function automatic void add(input bit tick, input bit pv, input int pin, input bit note,
                                input int el, input int per, input bit valid, input bit wrap);
        vec_t v;
        v.tick = tick; v.pv = pv; v.pin = W'(pin); v.note = note;
        v.el = W'(el); v.per = W'(per); v.valid = valid; v.wrap = wrap;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int el, input int per, input bit valid, input bit wrap);
        $display("%s: elapsed=%0d period_out=%0d out_valid=%0d wrap=%0d", tag,
                 bus_if.elapsed, bus_if.period_out, bus_if.out_valid, bus_if.wrap);
        chk({tag, ".elapsed"},    int'(bus_if.elapsed),    el);
        chk({tag, ".period_out"}, int'(bus_if.period_out), per);
        chk({tag, ".out_valid"},  int'(bus_if.out_valid),  int'(valid));
        chk({tag, ".wrap"},       int'(bus_if.wrap),       int'(wrap));
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic apply(input bit tick, input bit pv, input int pin, input bit note);
        bus_if.sample_tick  = tick;
        bus_if.period_valid = pv;
        bus_if.period_in    = W'(pin);
        bus_if.note_on      = note;
        @(posedge clk);
        #1;
        bus_if.sample_tick  = 1'b0;
        bus_if.period_valid = 1'b0;
        bus_if.period_in    = '0;
        bus_if.note_on      = 1'b0;
    endtask

    // Model step written from the rules: phase advances modulo the period.
    task automatic model_step(input bit tick, input bit pv, input int pin, input bit note);
        m_wrap = 1'b0;
        if (pv && pin == 0) begin
            m_per = 0; m_el = 0; m_has_pend = 1'b0; m_pend = 0;
        end else if (m_per == 0) begin
            if (pv) begin
                m_per = pin; m_el = 0;
            end
        end else if (note && NOTE_EN) begin
            m_el = 0;
            if (pv) m_per = pin;
            else if (m_has_pend) m_per = m_pend;
            m_has_pend = 1'b0; m_pend = 0;
        end else begin
            if (tick) begin
                m_wrap = ((m_el + 1) == m_per);
                m_el   = (m_el + 1) % m_per;
            end
            if (m_wrap) begin
                if (pv) m_per = pin;
                else if (m_has_pend) m_per = m_pend;
                m_has_pend = 1'b0; m_pend = 0;
            end else if (pv) begin
                m_has_pend = 1'b1; m_pend = pin;
            end
        end
    endtask

    initial begin
        bus_if.sample_tick  = 1'b0;
        bus_if.period_valid = 1'b0;
        bus_if.period_in    = '0;
        bus_if.note_on      = 1'b0;

        // tick pv pin note | el per valid wrap
        // Load 4 and count nine ticks.
        add(0,1,4,0, 0,4,1,0);
        add(1,0,0,0, 1,4,1,0); add(1,0,0,0, 2,4,1,0); add(1,0,0,0, 3,4,1,0);
        add(1,0,0,0, 0,4,1,1); add(1,0,0,0, 1,4,1,0); add(1,0,0,0, 2,4,1,0);
        add(1,0,0,0, 3,4,1,0); add(1,0,0,0, 0,4,1,1); add(1,0,0,0, 1,4,1,0);
        add(0,0,0,0, 1,4,1,0);
        // Stop, then deferred update 5 -> 3.
        add(0,1,0,0, 0,0,0,0);
        add(0,1,5,0, 0,5,1,0);
        add(1,0,0,0, 1,5,1,0); add(1,0,0,0, 2,5,1,0);
        add(0,1,3,0, 2,5,1,0);
        add(1,0,0,0, 3,5,1,0); add(1,0,0,0, 4,5,1,0);
        add(1,0,0,0, 0,3,1,1); add(1,0,0,0, 1,3,1,0);
        // Coincident update of period 4 with 7 at the wrap.
        add(0,1,0,0, 0,0,0,0);
        add(0,1,4,0, 0,4,1,0);
        add(1,0,0,0, 1,4,1,0); add(1,0,0,0, 2,4,1,0); add(1,0,0,0, 3,4,1,0);
        add(1,1,7,0, 0,7,1,1);
        add(1,0,0,0, 1,7,1,0);
        // Last queued request wins.
        add(0,1,2,0, 1,7,1,0); add(0,1,3,0, 1,7,1,0);
        add(1,0,0,0, 2,7,1,0); add(1,0,0,0, 3,7,1,0); add(1,0,0,0, 4,7,1,0);
        add(1,0,0,0, 5,7,1,0); add(1,0,0,0, 6,7,1,0);
        add(1,0,0,0, 0,3,1,1);
        // Period 1 and stop; ticks while stopped are ignored.
        add(0,1,0,0, 0,0,0,0);
        add(0,1,1,0, 0,1,1,0);
        add(1,0,0,0, 0,1,1,1); add(1,0,0,0, 0,1,1,1); add(1,0,0,0, 0,1,1,1);
        add(0,0,0,0, 0,1,1,0);
        add(0,1,0,0, 0,0,0,0);
        add(1,0,0,0, 0,0,0,0);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 0, 0, 0);
        chk_outs("tick_after_reset", 0, 0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            apply(tbl[i].tick, tbl[i].pv, int'(tbl[i].pin), tbl[i].note);
            chk_outs($sformatf("vec%0d", i), int'(tbl[i].el), int'(tbl[i].per),
                     tbl[i].valid, tbl[i].wrap);
        end

        // Asynchronous reset at elapsed 3 of period 6.
        apply(0, 1, 6, 0);
        for (int k = 0; k < 3; k++) apply(1, 0, 0, 0);
        chk_outs("pre_reset", 3, 6, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_outs("async_reset", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 0, 0, 0);
        chk_outs("post_reset_tick0", 0, 0, 1'b0, 1'b0);
        apply(1, 0, 0, 0);
        chk_outs("post_reset_tick1", 0, 0, 1'b0, 1'b0);

        // note_on at elapsed 5 of period 8.
        apply(0, 1, 8, 0);
        for (int k = 0; k < 5; k++) apply(1, 0, 0, 0);
        chk_outs("pre_note", 5, 8, 1'b1, 1'b0);
        apply(1, 0, 0, 1);
        chk_outs("note_tick", NOTE_EN ? 0 : 6, 8, 1'b1, 1'b0);
        apply(1, 0, 0, 1);
        chk_outs("note_tick2", NOTE_EN ? 0 : 7, 8, 1'b1, 1'b0);
        apply(0, 1, 3, 0);
        chk_outs("note_queue", NOTE_EN ? 0 : 7, 8, 1'b1, 1'b0);
        apply(1, 0, 0, 1);
        chk_outs("note_apply_pend", 0, 3, 1'b1, !NOTE_EN);

        // Randomized traffic against the model.
        rst_n = 1'b0;
        #1;
        m_per = 0; m_el = 0; m_pend = 0; m_has_pend = 1'b0; m_wrap = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit tick, pv, note;
            int pin;
            tick = ($urandom_range(0, 1) == 1);
            pv   = ($urandom_range(0, 9) == 0);
            pin  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            note = ($urandom_range(0, 19) == 0);
            model_step(tick, pv, pin, note);
            apply(tick, pv, pin, note);
            chk_outs($sformatf("rnd%0d", n), m_el, m_per, (m_per != 0), m_wrap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
